// File: rtl/boot_rom_pkg.sv
// Shared constants and types for the boot ROM arbiter.
package boot_rom_pkg;

    localparam int unsigned ROM_AW    = 10;
    localparam int unsigned ROM_DEPTH = 800;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } rom_port_e;

    typedef struct packed {
        logic      valid;
        rom_port_e port;
        logic      err;
    } rsp_t;

endpackage

// File: rtl/boot_rom_arb_core.sv
// Two-input arbiter for the boot ROM. Defining BOOT_ROM_ARB_RR_EN selects
// round-robin; otherwise port 0 (instruction fetch) has fixed priority.
module boot_rom_arb_core
    import boot_rom_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output rom_port_e  winner
);

`ifdef BOOT_ROM_ARB_RR_EN
    rom_port_e rr_last_q;

    always_comb begin
        winner = PORT_INSTR;
        if (req == 2'b11) begin
            winner = (rr_last_q == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
        end else if (req[1]) begin
            winner = PORT_DATA;
        end
        gnt = '0;
        if (|req) begin
            gnt = (winner == PORT_DATA) ? 2'b10 : 2'b01;
        end
    end

    // Pointer follows every grant, including ones that end in an error.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rr_last_q <= PORT_DATA;
        end else if (|req) begin
            rr_last_q <= winner;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RSTN;

    always_comb begin
        winner = (!req[0] && req[1]) ? PORT_DATA : PORT_INSTR;
        gnt    = '0;
        if (|req) begin
            gnt = (winner == PORT_DATA) ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-port boot ROM between instruction fetch and data/debug
// ports; arbitration mode is chosen by BOOT_ROM_ARB_RR_EN (see arb core).
module boot_rom_arbiter
    import boot_rom_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ROM_AW     = boot_rom_pkg::ROM_AW,
    parameter int unsigned ROM_DEPTH  = boot_rom_pkg::ROM_DEPTH
)(
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 we_i,
    input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
    output logic [1:0]                 gnt_o,
    output logic [1:0]                 rvalid_o,
    output logic [1:0][31:0]           rdata_o,
    output logic [1:0]                 err_o,
    output logic                       rom_csn_o,
    output logic [ROM_AW-1:0]          rom_addr_o,
    input  logic [31:0]                rom_rdata_i
);

    logic [1:0]            gnt;
    rom_port_e             winner;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [ROM_AW-1:0]     word;
    logic                  granted;
    logic                  err;
    logic                  rsp_idx;
    rsp_t                  rsp_q;
    logic                  unused_addr_bits;

    boot_rom_arb_core u_arb (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .req    (req_i),
        .gnt    (gnt),
        .winner (winner)
    );

    assign gnt_o    = gnt;
    assign granted  = |gnt;
    assign sel_addr = (winner == PORT_DATA) ? addr_i[1] : addr_i[0];
    assign sel_we   = (winner == PORT_DATA) ? we_i[1]   : we_i[0];
    assign word     = sel_addr[ROM_AW+1:2];

    // Region decode happens upstream, so bits above the ROM window are dropped.
    assign unused_addr_bits = ^{addr_i[1][ADDR_WIDTH-1:ROM_AW+2],
                                addr_i[0][ADDR_WIDTH-1:ROM_AW+2]};

    assign err = sel_we
               | (sel_addr[1:0] != 2'b00)
               | ({1'b0, word} >= (ROM_AW+1)'(ROM_DEPTH));

    assign rom_csn_o  = !(granted && !err);
    assign rom_addr_o = granted ? word : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rsp_q <= '0;
        end else begin
            rsp_q.valid <= granted;
            rsp_q.port  <= winner;
            rsp_q.err   <= granted & err;
        end
    end

    assign rsp_idx = rsp_q.port;

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        if (rsp_q.valid) begin
            rvalid_o[rsp_idx] = 1'b1;
            err_o[rsp_idx]    = rsp_q.err;
            rdata_o[rsp_idx]  = rsp_q.err ? '0 : rom_rdata_i;
        end
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Scoreboard bench for boot_rom_arbiter with a behavioural ROM; covers both
// arbitration modes depending on BOOT_ROM_ARB_RR_EN.
module tb_boot_rom_arbiter;

    logic             CLK;
    logic             RSTN;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
    logic [1:0]       err;
    logic             rom_csn;
    logic [9:0]       rom_addr;
    logic [31:0]      rom_rdata;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    boot_rom_arbiter #(.ADDR_WIDTH(32), .ROM_AW(10), .ROM_DEPTH(800)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .rom_csn_o   (rom_csn),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_word(input logic [9:0] w);
        case (w)
            10'd0:   return 32'h0000_0013;
            10'd31:  return 32'h0100_006F;
            default: return {16'hB00D, 6'h00, w};
        endcase
    endfunction

    // Behavioural ROM: address registered while selected, Q combinational.
    logic [9:0] rom_aq = '0;
    always @(posedge CLK) if (!rom_csn) rom_aq <= rom_addr;
    assign rom_rdata = rom_word(rom_aq);

    // Response monitor: every cycle the outputs must match the scoreboard head or be idle.
    logic [1:0]       m_rv;
    logic [1:0][31:0] m_rd;
    logic [1:0]       m_er;
    exp_t             m_e;
    always @(posedge CLK) begin
        #2;
        m_rv = '0;
        m_rd = '0;
        m_er = '0;
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            m_rv[m_e.port] = 1'b1;
            m_rd[m_e.port] = m_e.data;
            m_er[m_e.port] = m_e.err;
        end
        checks++;
        if (rvalid !== m_rv) begin
            failures++;
            $display("FAIL rsp_rvalid t=%0t got=%b exp=%b", $time, rvalid, m_rv);
        end
        checks++;
        if (rdata !== m_rd) begin
            failures++;
            $display("FAIL rsp_rdata t=%0t got=%h exp=%h", $time, rdata, m_rd);
        end
        checks++;
        if (err !== m_er) begin
            failures++;
            $display("FAIL rsp_err t=%0t got=%b exp=%b", $time, err, m_er);
        end
    end

    task automatic push(input logic p, input logic e, input logic [31:0] d);
        exp_t x;
        x.port = p;
        x.err  = e;
        x.data = d;
        sb.push_back(x);
    endtask

    // Apply inputs just after a rising edge; return at the following falling edge.
    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1);
        @(posedge CLK);
        #1;
        req     = r;
        we      = w;
        addr[0] = a0;
        addr[1] = a1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if ({gnt, rvalid, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {gnt, rvalid, err});
        end
        checks++;
        if (rdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        checks++;
        if (rom_csn !== 1'b1 || rom_addr !== 10'd0) begin
            failures++;
            $display("FAIL reset_rom got csn=%b addr=%0d exp csn=1 addr=0", rom_csn, rom_addr);
        end
        RSTN = 1'b1;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 32'h0, 32'h7C);
`ifdef BOOT_ROM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            checks++;
            if (gnt !== exp_g) begin
                failures++;
                $display("FAIL contention_gnt i=%0d got=%b exp=%b", i, gnt, exp_g);
            end
            if (exp_g == 2'b01) push(1'b0, 1'b0, rom_word(10'd0));
            else                push(1'b1, 1'b0, rom_word(10'd31));
        end
        drive(2'b10, 2'b00, 32'h0, 32'h7C);
        checks++;
        if (gnt !== 2'b10 || rom_addr !== 10'd31) begin
            failures++;
            $display("FAIL drop_req0_gnt got gnt=%b addr=%0d exp gnt=10 addr=31", gnt, rom_addr);
        end
        push(1'b1, 1'b0, rom_word(10'd31));
        drive(2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_single_read();
        drive(2'b01, 2'b00, 32'h7C, 32'h0);
        checks++;
        if (gnt !== 2'b01 || rom_csn !== 1'b0 || rom_addr !== 10'd31) begin
            failures++;
            $display("FAIL single_read got gnt=%b csn=%b addr=%0d exp gnt=01 csn=0 addr=31",
                     gnt, rom_csn, rom_addr);
        end
        push(1'b0, 1'b0, 32'h0100_006F);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_errors();
        logic [31:0] ea[4] = '{32'h10, 32'h12, 32'hC80, 32'hC7C};
        logic        ew[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [9:0]  wd[4] = '{10'd4, 10'd4, 10'd800, 10'd799};
        logic        ee[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, {ew[i], 1'b0}, 32'h0, ea[i]);
            checks++;
            if (gnt !== 2'b10 || rom_csn !== ee[i] || rom_addr !== wd[i]) begin
                failures++;
                $display("FAIL err_case i=%0d got gnt=%b csn=%b addr=%0d exp gnt=10 csn=%b addr=%0d",
                         i, gnt, rom_csn, rom_addr, ee[i], wd[i]);
            end
            push(1'b1, ee[i], ee[i] ? 32'h0 : rom_word(wd[i]));
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int unsigned w = 5; w <= 7; w++) begin
            drive(2'b01, 2'b00, w << 2, 32'h0);
            checks++;
            if (gnt !== 2'b01 || rom_csn !== 1'b0 || rom_addr !== 10'(w)) begin
                failures++;
                $display("FAIL b2b_addr w=%0d got gnt=%b csn=%b addr=%0d", w, gnt, rom_csn, rom_addr);
            end
            push(1'b0, 1'b0, rom_word(10'(w)));
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        checks++;
        if (gnt !== 2'b00 || rom_csn !== 1'b1 || rom_addr !== 10'd0) begin
            failures++;
            $display("FAIL idle_rom got gnt=%b csn=%b addr=%0d exp gnt=00 csn=1 addr=0",
                     gnt, rom_csn, rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 2'b00, 32'h14, 32'h0);
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_gnt got=%b exp=01", gnt);
        end
        #2;
        req  = 2'b00;
        RSTN = 1'b0;
        @(negedge CLK);
        checks++;
        if ({gnt, rvalid, err} !== 6'b0 || rdata !== 64'h0 || rom_csn !== 1'b1 || rom_addr !== 10'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got gnt=%b rv=%b err=%b rdata=%h csn=%b addr=%0d",
                     gnt, rvalid, err, rdata, rom_csn, rom_addr);
        end
        RSTN = 1'b1;
        drive(2'b11, 2'b00, 32'h0, 32'h7C);
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_first_contention got=%b exp=01", gnt);
        end
        push(1'b0, 1'b0, rom_word(10'd0));
        drive(2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        RSTN = 1'b0;
        req  = '0;
        we   = '0;
        addr = '0;
        test_reset();
        test_contention();
        test_single_read();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
